// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; result returns 2 edges after accept.
// Request is refused outside IDLE; a stalled response holds RESP and all outputs until the owner takes it.
module alu_arbiter #(
    parameter int alu_op_size      = 4,
    parameter int alu_operand_size = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid_0,
    input  logic                        req_valid_1,
    output logic                        req_ready_0,
    output logic                        req_ready_1,
    input  logic [alu_op_size-1:0]      req_alu_op_0,
    input  logic [alu_op_size-1:0]      req_alu_op_1,
    input  logic [alu_operand_size-1:0] req_op1_0,
    input  logic [alu_operand_size-1:0] req_op1_1,
    input  logic [alu_operand_size-1:0] req_op2_0,
    input  logic [alu_operand_size-1:0] req_op2_1,
    input  logic [2:0]                  req_branch_0,
    input  logic [2:0]                  req_branch_1,
    output logic                        rsp_valid_0,
    output logic                        rsp_valid_1,
    input  logic                        rsp_ready_0,
    input  logic                        rsp_ready_1,
    output logic [alu_operand_size-1:0] rsp_result,
    output logic                        rsp_zero,
    output logic [alu_op_size-1:0]      alu_op,
    output logic [alu_operand_size-1:0] alu_op1,
    output logic [alu_operand_size-1:0] alu_op2,
    output logic [2:0]                  alu_branch,
    input  logic [alu_operand_size-1:0] alu_result,
    input  logic                        alu_zero,
    output logic                        busy,
    output logic                        grant_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                      state_q, state_d;
    logic                        prio_q, prio_d;
    logic                        grant_q, grant_d;
    logic                        busy_q, busy_d;
    logic [1:0]                  rsp_valid_q, rsp_valid_d;
    logic [alu_op_size-1:0]      op_q, op_d;
    logic [alu_operand_size-1:0] op1_q, op1_d;
    logic [alu_operand_size-1:0] op2_q, op2_d;
    logic [2:0]                  br_q, br_d;
    logic [alu_operand_size-1:0] result_q, result_d;
    logic                        zero_q, zero_d;
    logic                        any_vld;
    logic                        win;
    logic                        owner_rdy;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        op_d        = op_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        br_d        = br_q;
        result_d    = result_q;
        zero_d      = zero_q;

        any_vld   = req_valid_0 | req_valid_1;
        win       = (req_valid_0 && req_valid_1) ? prio_q : req_valid_1;
        owner_rdy = grant_q ? rsp_ready_1 : rsp_ready_0;

        // Ready is gated by rst_n so it reads 0 while reset is held.
        req_ready_0 = rst_n && (state_q == IDLE) && any_vld && !win;
        req_ready_1 = rst_n && (state_q == IDLE) && any_vld && win;

        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    state_d = EXEC;
                    busy_d  = 1'b1;
                    grant_d = win;
                    op_d    = win ? req_alu_op_1 : req_alu_op_0;
                    op1_d   = win ? req_op1_1    : req_op1_0;
                    op2_d   = win ? req_op2_1    : req_op2_0;
                    br_d    = win ? req_branch_1 : req_branch_0;
                end
            end
            EXEC: begin
                state_d  = RESP;
                result_d = alu_result;
                // A floating or unknown flag must land as 0, so only a true 1 sets it.
                zero_d   = 1'b0;
                if (alu_zero) begin
                    zero_d = 1'b1;
                end
                rsp_valid_d = grant_q ? 2'b10 : 2'b01;
            end
            RESP: begin
                if (owner_rdy) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    rsp_valid_d = 2'b00;
                    prio_d      = !grant_q;
                end
            end
            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
            op_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            br_q        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            op_q        <= op_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            br_q        <= br_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign rsp_valid_0 = rsp_valid_q[0];
    assign rsp_valid_1 = rsp_valid_q[1];
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign alu_op      = op_q;
    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_branch  = br_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int OPW = 4;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [OPW-1:0] req_alu_op_0, req_alu_op_1;
    logic [DW-1:0]  req_op1_0, req_op1_1, req_op2_0, req_op2_1;
    logic [2:0]     req_branch_0, req_branch_1;
    logic           rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
    logic [DW-1:0]  rsp_result;
    logic           rsp_zero;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_op1, alu_op2, alu_result;
    logic [2:0]     alu_branch;
    wire            alu_zero;
    logic           busy, grant_id;

    alu_arbiter #(.alu_op_size(OPW), .alu_operand_size(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_alu_op_0(req_alu_op_0), .req_alu_op_1(req_alu_op_1),
        .req_op1_0(req_op1_0), .req_op1_1(req_op1_1),
        .req_op2_0(req_op2_0), .req_op2_1(req_op2_1),
        .req_branch_0(req_branch_0), .req_branch_1(req_branch_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_branch(alu_branch),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    // Local op encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT; branch 0 none, 1 BEQ, 2 BNE.
    function automatic logic [DW-1:0] ref_alu(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_zero(input logic [2:0] br, input logic [DW-1:0] r);
        case (br)
            3'd1: return r == '0;
            3'd2: return r != '0;
            default: return 1'b0;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_op, alu_op1, alu_op2);
    assign alu_zero   = (alu_branch == 3'd1 || alu_branch == 3'd2) ? ref_zero(alu_branch, alu_result) : 1'bz;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Pending request per requester and the round-robin pointer of the model.
    logic           p_vld [2];
    logic [OPW-1:0] p_op  [2];
    logic [DW-1:0]  p_a   [2];
    logic [DW-1:0]  p_b   [2];
    logic [2:0]     p_br  [2];
    int             model_prio;

    task automatic drive_reqs();
        req_valid_0 = p_vld[0]; req_alu_op_0 = p_op[0]; req_op1_0 = p_a[0]; req_op2_0 = p_b[0]; req_branch_0 = p_br[0];
        req_valid_1 = p_vld[1]; req_alu_op_1 = p_op[1]; req_op1_1 = p_a[1]; req_op2_1 = p_b[1]; req_branch_1 = p_br[1];
    endtask

    task automatic set_req(input int r, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] br);
        p_vld[r] = 1'b1; p_op[r] = op; p_a[r] = a; p_b[r] = b; p_br[r] = br;
        drive_reqs();
    endtask

    task automatic rand_req(input int r);
        set_req(r, OPW'($urandom_range(0, 7)), $urandom, $urandom, 3'($urandom_range(0, 2)));
    endtask

    function automatic logic vld_of(input int r);
        return (r == 0) ? rsp_valid_0 : rsp_valid_1;
    endfunction

    // One complete transaction starting in IDLE on a negedge; ends on the negedge after the handshake.
    task automatic run_txn(input int stall, input bit late);
        int            w, o;
        logic [DW-1:0] exp_res;
        logic          exp_z;
        drive_reqs();
        #1;
        w = (p_vld[0] && p_vld[1]) ? model_prio : (p_vld[0] ? 0 : 1);
        o = 1 - w;
        check_eq("grant_ready_0", req_ready_0, w == 0);
        check_eq("grant_ready_1", req_ready_1, w == 1);
        exp_res = ref_alu(p_op[w], p_a[w], p_b[w]);
        exp_z   = ref_zero(p_br[w], exp_res);
        @(posedge clk);
        @(negedge clk);
        p_vld[w] = 1'b0;
        if (late && !p_vld[o]) rand_req(o);
        drive_reqs();
        #1;
        check_eq("exec_busy", busy, 1'b1);
        check_eq("exec_grant_id", grant_id, w[0]);
        check_eq("exec_alu_op1", alu_op1, p_a[w]);
        check_eq("exec_alu_op2", alu_op2, p_b[w]);
        check_eq("exec_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        check_eq("exec_req_ready", {req_ready_1, req_ready_0}, 2'b00);
        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) begin
                if (w == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
            end
            // A short-lived request while busy must never be taken.
            if (stall >= 2 && i == 0 && !p_vld[o]) begin
                if (o == 0) req_valid_0 = 1'b1; else req_valid_1 = 1'b1;
            end
            if (i == 1) drive_reqs();
            #1;
            check_eq("resp_valid_owner", vld_of(w), 1'b1);
            check_eq("resp_valid_other", vld_of(o), 1'b0);
            check_eq("resp_result", rsp_result, exp_res);
            check_eq("resp_zero", rsp_zero, exp_z);
            check_eq("resp_busy", busy, 1'b1);
            check_eq("resp_req_ready", {req_ready_1, req_ready_0}, 2'b00);
            @(negedge clk);
        end
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b0;
        #1;
        check_eq("done_busy", busy, 1'b0);
        check_eq("done_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        model_prio = o;
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            p_vld[r] = 1'b0; p_op[r] = '0; p_a[r] = '0; p_b[r] = '0; p_br[r] = '0;
        end
        model_prio  = 0;
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b0;
        drive_reqs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_grant_id", grant_id, 1'b0);
        check_eq("rst_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        check_eq("rst_req_ready", {req_ready_1, req_ready_0}, 2'b00);
        check_eq("rst_rsp_result", rsp_result, '0);
        check_eq("rst_rsp_zero", rsp_zero, 1'b0);
        check_eq("rst_alu_ops", {alu_op, alu_branch}, '0);
        check_eq("rst_alu_op1", alu_op1 | alu_op2, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention from reset: 0 first, then 1, then a new pair starts with 0 again.
        set_req(0, 4'd1, 32'd10, 32'd3, 3'd0);
        set_req(1, 4'd4, 32'hF0, 32'hFF, 3'd0);
        run_txn(0, 1'b0);
        check_eq("contend_first_result", rsp_result, 32'd7);
        run_txn(0, 1'b0);
        check_eq("contend_second_result", rsp_result, 32'h0F);
        rand_req(0);
        rand_req(1);
        run_txn(0, 1'b0);
        check_eq("contend_pair_owner", grant_id, 1'b0);
        run_txn(0, 1'b0);

        set_req(0, 4'd0, 32'd5, 32'd7, 3'd0);
        run_txn(0, 1'b0);
        check_eq("single_add_result", rsp_result, 32'd12);

        set_req(1, 4'd1, 32'd3, 32'd3, 3'd1);
        run_txn(0, 1'b0);
        check_eq("beq_zero_flag", rsp_zero, 1'b1);

        set_req(0, 4'd1, 32'd3, 32'd3, 3'd0);
        run_txn(0, 1'b0);
        check_eq("nobranch_zero_flag", rsp_zero, 1'b0);

        set_req(1, 4'd2, 32'hFFFF_0000, 32'h1234_5678, 3'd0);
        run_txn(0, 1'b0);
        set_req(0, 4'd0, 32'd1, 32'd2, 3'd0);
        run_txn(5, 1'b1);
        while (p_vld[0] || p_vld[1]) run_txn(0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            if (!p_vld[0] && $urandom_range(0, 1) == 1) rand_req(0);
            if (!p_vld[1] && $urandom_range(0, 1) == 1) rand_req(1);
            if (!p_vld[0] && !p_vld[1]) rand_req($urandom_range(0, 1));
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        while (p_vld[0] || p_vld[1]) run_txn(0, 1'b0);

        // Reset during EXEC with the pointer at 1: the next pair must go to requester 0.
        set_req(0, 4'd0, 32'd5, 32'd7, 3'd0);
        run_txn(0, 1'b0);
        set_req(1, 4'd0, 32'd100, 32'd23, 3'd0);
        #1;
        check_eq("midrst_accept", req_ready_1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("midrst_exec_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        check_eq("midrst_rsp_result", rsp_result, '0);
        check_eq("midrst_alu_op1", alu_op1, '0);
        check_eq("midrst_req_ready", {req_ready_1, req_ready_0}, 2'b00);
        p_vld[1] = 1'b0;
        drive_reqs();
        model_prio = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_eq("postrst_no_rsp", {rsp_valid_1, rsp_valid_0, busy}, 3'b000);
        rand_req(0);
        rand_req(1);
        run_txn(0, 1'b0);
        check_eq("postrst_owner", grant_id, 1'b0);
        run_txn(1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
